pipe_stage_ctrl: RTL
====================

Name: pipe_stage_ctrl

Overview:
- Parametrised pipeline sequencing controller for the MIPS core family.
- Generates per-stage enable, bubble-insert (register clear) and valid signals for an N-stage in-order pipeline from per-stage stall and flush requests.
- Keeps wrap-around performance counters for cycles, stall cycles and retired instructions.
- Sits beside the controller; its outputs drive the datapath pipeline registers. Replaces hand-written fixed 5-stage if/id/exe/mem/wb enable logic.

Parameters:
NSTAGE, 5, number of pipeline stages; index 0 = IF (youngest), NSTAGE-1 = WB (oldest); legal range 2..16
CNT_W, 32, width of each performance counter

Ports:
clk  input  1  main clock
rst  input  1  synchronous reset, active-low
stall_req  input  NSTAGE  bit k: stage k cannot advance this cycle
flush_req  input  NSTAGE  bit k: stage k redirects the PC; all younger stages are killed
cnt_clr  input  1  synchronous clear of all performance counters
stage_en  output  NSTAGE  bit i: register feeding stage i loads this cycle (bit 0 = PC)
stage_rst  output  NSTAGE  bit i: register feeding stage i loads a bubble this cycle
stage_valid  output  NSTAGE  bit i: stage i holds a live instruction (registered)
cyc_cnt  output  CNT_W  cycles since reset or clear
stall_cnt  output  CNT_W  cycles with stage_en[0]==0
retire_cnt  output  CNT_W  instructions leaving stage NSTAGE-1

Behaviour:
- Reset (rst==0 at clk edge):
  - stage_valid <= 0 and all counters <= 0.
  - While rst==0, combinational outputs are stage_en = all 1 and stage_rst = all 1.
- Request qualification: stall_req[k] and flush_req[k] are honoured only when stage_valid[k]==1. Bit 0 is always honoured (IF has no live predecessor).
- Flush resolution:
  - F = highest index with a qualified flush; "none" if no qualified flush.
  - Stall requests at indices <= F are ignored, because those instructions are dead.
- Stall resolution:
  - S = highest index with a qualified, non-ignored stall; "none" if absent.
  - An older stall overrides a younger flush. The flushing stage is frozen, so its flush_req must stay high until the stall clears.
- Output equations (combinational from requests and stage_valid, zero-cycle latency):
  - S defined: stage_en[i]=0 for i<=S. stage_en[S+1]=1 with stage_rst[S+1]=1 (bubble), when S+1<NSTAGE. stage_en=1 and stage_rst=0 for i>S+1.
  - Else F defined: stage_en = all 1; stage_rst[i]=1 for 1<=i<=F; stage_rst[0]=0, since the PC loads the redirect target.
  - Else: stage_en = all 1, stage_rst = all 0.
- Valid tracking:
  - Register updates only when stage_en[i]==1.
  - valid[i] <= stage_rst[i] ? 0 : (i==0 ? 1 : valid[i-1]).
  - After reset release, valid[0] rises on the first edge and the valid bits fill one stage per cycle.
- Counters:
  - Updates each edge when rst==1.
  - cnt_clr has priority: all counters <= 0.
  - Otherwise cyc_cnt+1; stall_cnt+1 if stage_en[0]==0; retire_cnt+1 if stage_valid[NSTAGE-1] && stage_en[NSTAGE-1].
  - All counters wrap modulo 2^CNT_W without saturating.
- Simultaneous events:
  - Flush and stall at the same index k: the flush wins (the stall is ignored since k <= F).
  - Multiple flushes: the oldest (highest index) wins.
  - Reset mid-operation discards all in-flight state in one cycle.

Optional Feature:
- Macro: PIPE_DEBUG_STEP_EN.
- When defined, add two inputs:
  - debug_en (1), freeze the pipeline for single-step.
  - debug_step (1), asynchronous step button.
- debug_step passes through a 2-flop synchroniser plus rising-edge detect.
- While debug_en==1:
  - stage_en is forced to all 0 and stage_rst to all 0, except in the single cycle when a synchronised rising edge is detected. That cycle uses the normal equations.
  - Edge-to-step latency is 3 clk edges.
  - Counters do not increment in frozen cycles.
- Reset clears the synchroniser flops.
- Undefined: ports absent, pipeline free-runs, no extra flops.

Test Plan:
- Reset and fill, NSTAGE=5, no requests: rst low for 2 cycles, then high. stage_valid goes 00001 → 00011 → 00111 → 01111 → 11111 over 5 edges. retire_cnt first increments on edge 6.
- Load-use stall, full pipe: stall_req=00010 for 1 cycle. Required: stage_en=11100, stage_rst=00100; stall_cnt +1; valid[2]=0 the next cycle.
- Branch flush, full pipe: flush_req=00100 for 1 cycle. Required: stage_en=11111, stage_rst=00110; next cycle stage_valid=11001.
- Stall vs flush, full pipe: stall_req=01000 with flush_req=00100. Stall wins: stage_en=10000, stage_rst=10000. Hold both 2 cycles, then drop the stall. Flush takes effect with stage_rst=00110.
- Counter wrap and clear, CNT_W=4: run 17 cycles → cyc_cnt=1. Assert cnt_clr with retire → all counters 0 on that edge.
- With PIPE_DEBUG_STEP_EN: debug_en=1, one debug_step pulse. stage_en = all 1 on exactly one cycle, 3 edges after the pulse. cyc_cnt advances by exactly 1.

Source files
------------

// File: rtl/pipe_stage_ctrl_if.sv
// Request/response bundle between the pipeline controller and its datapath/control neighbours.
interface pipe_stage_ctrl_if #(
   parameter int unsigned NSTAGE = 5,
   parameter int unsigned CNT_W  = 32
);
   logic [NSTAGE-1:0] stall_req;
   logic [NSTAGE-1:0] flush_req;
   logic              cnt_clr;
   logic [NSTAGE-1:0] stage_en;
   logic [NSTAGE-1:0] stage_rst;
   logic [NSTAGE-1:0] stage_valid;
   logic [CNT_W-1:0]  cyc_cnt;
   logic [CNT_W-1:0]  stall_cnt;
   logic [CNT_W-1:0]  retire_cnt;

   modport master (
      output stall_req, flush_req, cnt_clr,
      input  stage_en, stage_rst, stage_valid, cyc_cnt, stall_cnt, retire_cnt
   );

   modport slave (
      input  stall_req, flush_req, cnt_clr,
      output stage_en, stage_rst, stage_valid, cyc_cnt, stall_cnt, retire_cnt
   );
endinterface

// File: rtl/pipe_stage_ctrl.sv
// N-stage in-order pipeline sequencer: per-stage enable/bubble/valid plus performance counters.
// Optional single-step debug freeze is enabled by defining PIPE_DEBUG_STEP_EN.
module pipe_stage_ctrl #(
   parameter int unsigned NSTAGE = 5,
   parameter int unsigned CNT_W  = 32
) (
   input  logic clk,
   input  logic rst,
`ifdef PIPE_DEBUG_STEP_EN
   input  logic debug_en,
   input  logic debug_step,
`endif
   pipe_stage_ctrl_if.slave bus
);

   localparam int unsigned IDX_W = (NSTAGE > 1) ? $clog2(NSTAGE) : 1;

   logic [NSTAGE-1:0] vld_q, vld_d;
   logic [NSTAGE-1:0] qual_mask;
   logic [NSTAGE-1:0] qual_stall, qual_flush;
   logic [NSTAGE-1:0] en_c, rs_c;
   logic              f_vld, s_vld;
   logic [IDX_W-1:0]  f_idx, s_idx;
   logic              frozen;
   logic [CNT_W-1:0]  cyc_q, cyc_d, stall_q, stall_d, ret_q, ret_d;

`ifdef PIPE_DEBUG_STEP_EN
   // Two-flop synchroniser plus a third flop for rising-edge detect
   logic [2:0] dbg_q;
   logic       step_c;

   always_ff @(posedge clk) begin
      if (!rst) dbg_q <= '0;
      else      dbg_q <= {dbg_q[1:0], debug_step};
   end

   assign step_c = dbg_q[1] & ~dbg_q[2];
   assign frozen = debug_en & ~step_c;
`else
   assign frozen = 1'b0;
`endif

   // Stage 0 has no live predecessor, so its requests are always honoured
   assign qual_mask  = {vld_q[NSTAGE-1:1], 1'b1};
   assign qual_stall = bus.stall_req & qual_mask;
   assign qual_flush = bus.flush_req & qual_mask;

   // Oldest flush wins; stalls at or below it belong to dead instructions
   always_comb begin
      f_vld = 1'b0;
      f_idx = '0;
      s_vld = 1'b0;
      s_idx = '0;
      for (int i = 0; i < int'(NSTAGE); i++) begin
         if (qual_flush[i]) begin
            f_vld = 1'b1;
            f_idx = IDX_W'(i);
         end
      end
      for (int i = 0; i < int'(NSTAGE); i++) begin
         if (qual_stall[i] && (!f_vld || (IDX_W'(i) > f_idx))) begin
            s_vld = 1'b1;
            s_idx = IDX_W'(i);
         end
      end
   end

   always_comb begin
      en_c = '1;
      rs_c = '0;
      if (!rst) begin
         rs_c = '1;
      end else if (frozen) begin
         en_c = '0;
      end else if (s_vld) begin
         for (int i = 0; i < int'(NSTAGE); i++) begin
            if (IDX_W'(i) <= s_idx)                     en_c[i] = 1'b0;
            else if (IDX_W'(i) == (s_idx + IDX_W'(1)))  rs_c[i] = 1'b1;
         end
      end else if (f_vld) begin
         // Stage 0 keeps loading: the PC takes the redirect target
         for (int i = 1; i < int'(NSTAGE); i++) begin
            if (IDX_W'(i) <= f_idx) rs_c[i] = 1'b1;
         end
      end
   end

   // Enabled stages take their predecessor's valid (or a bubble); others hold
   always_comb begin
      vld_d = (en_c & ~rs_c & {vld_q[NSTAGE-2:0], 1'b1}) | (~en_c & vld_q);
   end

   always_comb begin
      cyc_d   = cyc_q;
      stall_d = stall_q;
      ret_d   = ret_q;
      if (bus.cnt_clr) begin
         cyc_d   = '0;
         stall_d = '0;
         ret_d   = '0;
      end else if (!frozen) begin
         cyc_d = cyc_q + CNT_W'(1);
         if (!en_c[0])                          stall_d = stall_q + CNT_W'(1);
         if (vld_q[NSTAGE-1] && en_c[NSTAGE-1]) ret_d   = ret_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         vld_q   <= '0;
         cyc_q   <= '0;
         stall_q <= '0;
         ret_q   <= '0;
      end else begin
         vld_q   <= vld_d;
         cyc_q   <= cyc_d;
         stall_q <= stall_d;
         ret_q   <= ret_d;
      end
   end

   assign bus.stage_en    = en_c;
   assign bus.stage_rst   = rs_c;
   assign bus.stage_valid = vld_q;
   assign bus.cyc_cnt     = cyc_q;
   assign bus.stall_cnt   = stall_q;
   assign bus.retire_cnt  = ret_q;

endmodule
